// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl_pkg
//  Description : Shared types and default constants for the run sequencer.
//                Holds the sequencer state encoding and the default halt PC,
//                run timeout and preload length.
//  Revision    : 1.0  initial release
// ============================================================================
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int c_DONE_PC = 128;
    localparam int c_TIMEOUT = 4096;
    localparam int c_LOAD_N  = 64;

endpackage
`default_nettype wire

// File: rtl/rise_det.sv
`default_nettype none
// ============================================================================
//  Module      : rise_det
//  Description : 0->1 edge detector. The previous input value is registered;
//                o_rise is high in the cycle where i_d is 1 and was 0 on the
//                previous clock edge.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous active-high reset (history cleared)
//                i_d    - level input
//                o_rise - combinational rising-edge strobe
//  Revision    : 1.0  initial release
// ============================================================================
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl
//  Description : Run sequencer in front of the 9-bit-instruction core.
//                On a start edge it streams a preload image into data memory,
//                holds the core in reset for the load plus one clear cycle,
//                lets the core run until the PC reaches DONE_PC or TIMEOUT
//                run cycles elapse, then parks in DONE until req drops.
//  Ports       : clk, reset          - clock / async active-high reset
//                req                 - start request (acts on 0->1 edge)
//                ld_valid/ld_data    - preload byte stream
//                ld_ready            - preload byte accepted when ld_valid=1
//                mem_wr_en/addr/dat  - data memory write port
//                core_reset/core_en  - core reset and run enable
//                prog_ctr            - core program counter
//                done/timeout        - sticky completion status
//                cycles              - run-cycle count of current/last run
//  Revision    : 1.0  initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int D       = 9,
    parameter int DONE_PC = c_DONE_PC,
    parameter int LOAD_N  = c_LOAD_N,
    parameter int TIMEOUT = c_TIMEOUT,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_dat,
    output logic          core_reset,
    output logic          core_en,
    input  logic [D-1:0]  prog_ctr,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    // Last load index; unused when LOAD_N=0 because LOAD is skipped.
    localparam logic [7:0]    c_LAST      = 8'((LOAD_N > 0) ? (LOAD_N - 1) : 0);
    localparam logic [D-1:0]  c_HALT_PC   = D'(DONE_PC);
    localparam logic [CW-1:0] c_TMO_CNT   = CW'(TIMEOUT);
    localparam state_t        c_FIRST_ST  = (LOAD_N == 0) ? S_CLEAR : S_LOAD;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_ld_cnt;
    logic [CW-1:0] r_cycles;
    logic          r_done;
    logic          r_timeout;

    logic          w_start;
    logic          w_accept;
    logic          w_halt;
    logic          w_tmo;
    logic [CW-1:0] w_cycles_inc;

    rise_det u_start_det (
        .clk    (clk),
        .rst    (reset),
        .i_d    (req),
        .o_rise (w_start)
    );

    assign w_accept     = (r_state == S_LOAD) && ld_valid;
    assign w_cycles_inc = r_cycles + CW'(1);
    assign w_halt       = (prog_ctr == c_HALT_PC);
    // Timeout fires on the edge that brings the count up to TIMEOUT.
    assign w_tmo        = (w_cycles_inc == c_TMO_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 8'd0;
        mem_dat     = 8'd0;
        core_reset  = 1'b1;
        core_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_FIRST_ST;
                end
            end
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_wr_en = ld_valid;
                mem_addr  = r_ld_cnt;
                mem_dat   = ld_data;
                if (w_accept && (r_ld_cnt == c_LAST)) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                core_reset = 1'b0;
                core_en    = 1'b1;
                if (w_halt || w_tmo) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Core left out of reset so its state can be inspected.
                core_reset = 1'b0;
                if (!req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_cnt  <= 8'd0;
            r_cycles  <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_start) begin
                r_ld_cnt  <= 8'd0;
                r_cycles  <= '0;
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_accept) begin
                r_ld_cnt <= r_ld_cnt + 8'd1;
            end
            if (r_state == S_RUN) begin
                r_cycles <= w_cycles_inc;
                // Halt wins over timeout on the same edge.
                if (w_halt) begin
                    r_done    <= 1'b1;
                    r_timeout <= 1'b0;
                end else if (w_tmo) begin
                    r_done    <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign timeout = r_timeout;
    assign cycles  = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_ctrl
//  Description : Self-checking bench for run_ctrl (LOAD_N=4, TIMEOUT=16,
//                DONE_PC=128). Each run is described by its preload image,
//                the run edge on which the PC hits the halt address and the
//                valid/request pattern; expected writes, cycle count and
//                status are derived from those run-level quantities.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_run_ctrl;

    localparam int c_LOAD_N  = 4;
    localparam int c_TIMEOUT = 16;
    localparam int c_HALT    = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_dat;
    logic        core_reset;
    logic        core_en;
    logic [8:0]  prog_ctr;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;

    int n_total = 0;
    int n_bad   = 0;

    run_ctrl #(
        .D       (9),
        .DONE_PC (c_HALT),
        .LOAD_N  (c_LOAD_N),
        .TIMEOUT (c_TIMEOUT),
        .CW      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .core_reset (core_reset),
        .core_en    (core_en),
        .prog_ctr   (prog_ctr),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] nonhalt();
        logic [8:0] p;
        p = 9'($urandom_range(0, 511));
        if (p == 9'(c_HALT)) p = 9'(c_HALT + 1);
        return p;
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_ld_ready"},   ld_ready,   0);
        check({tag, "_wr_en"},      mem_wr_en,  0);
        check({tag, "_addr"},       mem_addr,   0);
        check({tag, "_dat"},        mem_dat,    0);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_core_en"},    core_en,    0);
        check({tag, "_done"},       done,       0);
        check({tag, "_timeout"},    timeout,    0);
        check({tag, "_cycles"},     cycles,     0);
    endtask

    // gap_mode: 0 = ld_valid always high, 1 = random gaps,
    //           2 = two idle cycles right before byte index 2.
    // halt_edge: run edge (1-based) on which prog_ctr equals DONE_PC.
    task automatic do_run(input int halt_edge, input int gap_mode, input bit rnd_req, input bit fixed_img);
        logic [7:0] img [c_LOAD_N];
        int  idx;
        int  budget;
        int  gap_cnt;
        int  exp_cyc;
        bit  exp_to;
        bit  v;
        int  hold;

        for (int i = 0; i < c_LOAD_N; i++)
            img[i] = fixed_img ? 8'(8'h11 * (i + 1)) : 8'($urandom);
        exp_cyc = (halt_edge <= c_TIMEOUT) ? halt_edge : c_TIMEOUT;
        exp_to  = (halt_edge > c_TIMEOUT);

        // IDLE: raise req to start
        req = 1'b1; ld_valid = 1'b0;
        #1;
        check("idle_core_reset", core_reset, 1);
        check("idle_core_en",    core_en,    0);
        check("idle_ld_ready",   ld_ready,   0);
        tick();
        check("start_done",    done,    0);
        check("start_timeout", timeout, 0);
        check("start_cycles",  cycles,  0);

        // LOAD
        idx = 0; budget = 0; gap_cnt = 0;
        while (idx < c_LOAD_N) begin
            case (gap_mode)
                1:       v = (budget < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
                2:       v = !(idx == 2 && gap_cnt < 2);
                default: v = 1'b1;
            endcase
            if (!v) gap_cnt++;
            ld_valid = v;
            ld_data  = v ? img[idx] : 8'($urandom);
            if (rnd_req) req = 1'($urandom);
            #1;
            check("ld_ready",      ld_ready,   1);
            check("ld_core_reset", core_reset, 1);
            check("ld_core_en",    core_en,    0);
            check("ld_wr_en",      mem_wr_en,  v);
            check("ld_addr",       mem_addr,   idx);
            if (v) check("ld_dat", mem_dat, img[idx]);
            tick();
            if (v) idx++;
            budget++;
        end

        // CLEAR
        ld_valid = 1'($urandom); ld_data = 8'($urandom);
        if (rnd_req) req = 1'($urandom);
        #1;
        check("clr_ld_ready",   ld_ready,   0);
        check("clr_wr_en",      mem_wr_en,  0);
        check("clr_core_reset", core_reset, 1);
        check("clr_core_en",    core_en,    0);
        tick();

        // RUN
        for (int e = 1; e <= exp_cyc; e++) begin
            prog_ctr = (e == halt_edge) ? 9'(c_HALT) : nonhalt();
            ld_valid = 1'($urandom);
            if (rnd_req) req = 1'($urandom);
            #1;
            check("run_core_en",    core_en,    1);
            check("run_core_reset", core_reset, 0);
            check("run_cycles",     cycles,     e - 1);
            check("run_done",       done,       0);
            check("run_wr_en",      mem_wr_en,  0);
            check("run_ld_ready",   ld_ready,   0);
            tick();
        end

        // DONE, req held high
        req = 1'b1; prog_ctr = nonhalt();
        #1;
        check("dn_done",       done,       1);
        check("dn_timeout",    timeout,    exp_to);
        check("dn_cycles",     cycles,     exp_cyc);
        check("dn_core_en",    core_en,    0);
        check("dn_core_reset", core_reset, 0);
        hold = $urandom_range(1, 3);
        repeat (hold) begin
            tick();
            prog_ctr = 9'($urandom_range(0, 511));
            #1;
            check("hold_done",    done,    1);
            check("hold_cycles",  cycles,  exp_cyc);
            check("hold_core_en", core_en, 0);
            check("hold_core_reset", core_reset, 0);
        end

        // drop req -> IDLE, status remains
        req = 1'b0;
        tick();
        check("back_core_reset", core_reset, 1);
        check("back_done",       done,       1);
        check("back_timeout",    timeout,    exp_to);
        check("back_cycles",     cycles,     exp_cyc);
    endtask

    task automatic reset_mid_load();
        req = 1'b1; ld_valid = 1'b0;
        #1;
        tick();
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 8'($urandom);
            tick();
        end
        ld_valid = 1'b1; ld_data = 8'hAB;
        #1;
        check("mid_addr", mem_addr, 2);
        #1;
        reset = 1'b1; req = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        reset = 1'b0; ld_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = 1'b0; ld_valid = 1'b0; ld_data = 8'd0; prog_ctr = 9'd0;
        #2;
        check_reset_outs("por");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_outs("post_rst");

        do_run(10,  0, 1'b0, 1'b1);   // halt on 10th run edge
        do_run(16,  2, 1'b0, 1'b0);   // gap before byte 2; halt on timeout edge
        do_run(100, 0, 1'b0, 1'b0);   // never halts -> timeout
        do_run(1,   0, 1'b0, 1'b0);   // halt on first run edge

        // async reset with sticky status present
        #1;
        reset = 1'b1;
        #1;
        check_reset_outs("idle_rst");
        reset = 1'b0;
        tick();

        reset_mid_load();
        do_run(5, 0, 1'b0, 1'b1);

        repeat (25) do_run($urandom_range(1, 24), 1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
